// File: rtl/ir_pi_line_cntrl_if.sv
// Sensor-scan / motor-command bundle between the line-follower PI controller
// and its environment (A2D converter, IR emitters, motor drivers, run control).
interface ir_pi_line_cntrl_if #(
  parameter int NUM_PAIRS = 3
);
  logic                   go;
  logic                   mode;
  logic                   cnv_cmplt;
  logic [11:0]            A2D_res;
  logic                   strt_cnv;
  logic [2:0]             chnnl;
  logic [NUM_PAIRS-1:0]   IR_en;
  logic [7:0]             LEDs;
  logic signed [11:0]     lft;
  logic signed [11:0]     rht;
  logic                   upd;
  logic                   err_sat;

  modport master (
    input  go, mode, cnv_cmplt, A2D_res,
    output strt_cnv, chnnl, IR_en, LEDs, lft, rht, upd, err_sat
  );

  modport slave (
    output go, mode, cnv_cmplt, A2D_res,
    input  strt_cnv, chnnl, IR_en, LEDs, lft, rht, upd, err_sat
  );
endinterface

// File: rtl/ir_pi_line_cntrl.sv
// Line-follower controller: scans IR sensor pairs through the A2D, builds a
// weighted saturated error and runs a PI loop with ramped forward speed.
module ir_pi_line_cntrl #(
  parameter int                     NUM_PAIRS  = 3,
  parameter logic [3*NUM_PAIRS-1:0] R_CHN      = {3'd3, 3'd4, 3'd1},
  parameter logic [3*NUM_PAIRS-1:0] L_CHN      = {3'd7, 3'd2, 3'd0},
  parameter int                     SETTLE_CYC = 4096,
  parameter int                     SHORT_CYC  = 32,
  parameter int                     PWM_PERIOD = 240,
  parameter int                     PWM_DUTY   = 140,
  parameter int                     P_GAIN     = 12,
  parameter int                     P_SHIFT    = 3,
  parameter int                     I_GAIN     = 5,
  parameter int                     I_SHIFT    = 3,
  parameter int                     INT_DEC    = 4,
  parameter int                     FWD_MAX    = 1792
) (
  input  logic                  clk,
  input  logic                  rst,
  ir_pi_line_cntrl_if.master    bus
);

  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int TW = $clog2((SETTLE_CYC > SHORT_CYC) ? SETTLE_CYC : SHORT_CYC) + 1;
  localparam int QW = $clog2(PWM_PERIOD) + 1;
  localparam int IW = $clog2(INT_DEC) + 1;

  localparam logic [PW-1:0]        P_LAST      = PW'(NUM_PAIRS - 1);
  localparam logic [TW-1:0]        SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]        SHORT_LAST  = TW'(SHORT_CYC - 1);
  localparam logic [QW-1:0]        PWM_LAST    = QW'(PWM_PERIOD - 1);
  localparam logic [QW-1:0]        PWM_HI      = QW'(PWM_DUTY);
  localparam logic [IW-1:0]        INT_LAST    = IW'(INT_DEC - 1);
  localparam logic signed [23:0]   P_G         = 24'(P_GAIN);
  localparam logic signed [23:0]   I_G         = 24'(I_GAIN);
  localparam logic signed [11:0]   FWD_CAP     = 12'(FWD_MAX);

  typedef enum logic [3:0] {
    IDLE, SETTLE, CONV_R, SHORT, CONV_L, ERR, INTG, PCMP, MOTOR
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      p_q;
  logic [TW-1:0]      timer_q;
  logic [QW-1:0]      pwm_q;
  logic [IW-1:0]      int_cnt_q;
  logic signed [17:0] accum_q;
  logic signed [11:0] error_q, intgrl_q, fwd_q, pcomp_q, icomp_q, lft_q, rht_q;
  logic               strt_cnv_q, upd_q, err_sat_q;
  logic [2:0]         chnnl_q;

  logic [PW-1:0]        p_nxt;
  logic signed [17:0]   a2d_sh;
  logic signed [11:0]   err_nxt, intgrl_nxt, lft_nxt, rht_nxt;
  logic signed [23:0]   p_full, i_full;
  logic                 err_clip;
  logic [NUM_PAIRS-1:0] ir_en;

  function automatic logic signed [11:0] sat12(input logic signed [23:0] v);
    if (v > 24'sd2047)  return 12'sd2047;
    if (v < -24'sd2048) return -12'sd2048;
    return v[11:0];
  endfunction

  // Sample weight 2^p is applied before accumulation (right adds, left subtracts).
  assign a2d_sh     = signed'({6'd0, bus.A2D_res}) <<< p_q;
  assign p_nxt      = p_q + 1'b1;
  assign err_nxt    = sat12(24'(accum_q));
  assign err_clip   = (accum_q > 18'sd2047) || (accum_q < -18'sd2048);
  assign intgrl_nxt = sat12(24'(intgrl_q) + 24'(error_q >>> 4));
  assign p_full     = (24'(error_q) * P_G) >>> P_SHIFT;
  assign i_full     = (24'(intgrl_q) * I_G) >>> I_SHIFT;
  assign lft_nxt    = sat12(24'(fwd_q) + 24'(pcomp_q) + 24'(icomp_q));
  assign rht_nxt    = sat12(24'(fwd_q) - 24'(pcomp_q) - 24'(icomp_q));

  always_comb begin
    // NOTE: default every bit before the conditional write so no latch is inferred.
    ir_en = '0;
    if ((state_q inside {SETTLE, CONV_R, SHORT, CONV_L}) && (pwm_q < PWM_HI))
      ir_en[p_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      timer_q    <= '0;
      pwm_q      <= '0;
      int_cnt_q  <= '0;
      accum_q    <= '0;
      error_q    <= '0;
      intgrl_q   <= '0;
      fwd_q      <= '0;
      pcomp_q    <= '0;
      icomp_q    <= '0;
      lft_q      <= '0;
      rht_q      <= '0;
      strt_cnv_q <= 1'b0;
      upd_q      <= 1'b0;
      err_sat_q  <= 1'b0;
      chnnl_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      strt_cnv_q <= 1'b0;
      upd_q      <= 1'b0;
      pwm_q      <= ((state_q == IDLE) || (pwm_q == PWM_LAST)) ? '0 : pwm_q + 1'b1;

      if (!bus.go) begin
        // Error, LEDs and err_sat deliberately survive a stop.
        state_q   <= IDLE;
        lft_q     <= '0;
        rht_q     <= '0;
        fwd_q     <= '0;
        intgrl_q  <= '0;
        int_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            p_q     <= '0;
            chnnl_q <= R_CHN[2:0];
            timer_q <= '0;
            accum_q <= '0;
            state_q <= SETTLE;
          end
          SETTLE: begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == SETTLE_LAST) begin
              strt_cnv_q <= 1'b1;
              state_q    <= CONV_R;
            end
          end
          CONV_R: if (bus.cnv_cmplt) begin
            accum_q <= accum_q + a2d_sh;
            chnnl_q <= L_CHN[3*p_q +: 3];
            timer_q <= '0;
            state_q <= SHORT;
          end
          SHORT: begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == SHORT_LAST) begin
              strt_cnv_q <= 1'b1;
              state_q    <= CONV_L;
            end
          end
          CONV_L: if (bus.cnv_cmplt) begin
            accum_q <= accum_q - a2d_sh;
            if (p_q != P_LAST) begin
              p_q     <= p_nxt;
              chnnl_q <= R_CHN[3*p_nxt +: 3];
              timer_q <= '0;
              state_q <= SETTLE;
            end else begin
              state_q <= ERR;
            end
          end
          ERR: begin
            error_q   <= err_nxt;
            err_sat_q <= err_clip;
            fwd_q     <= (fwd_q >= FWD_CAP) ? FWD_CAP : fwd_q + 12'sd1;
            state_q   <= INTG;
          end
          INTG: begin
            if (int_cnt_q == INT_LAST) begin
              int_cnt_q <= '0;
              if (!bus.mode) intgrl_q <= intgrl_nxt;
            end else begin
              int_cnt_q <= int_cnt_q + 1'b1;
            end
            state_q <= PCMP;
          end
          PCMP: begin
            pcomp_q <= sat12(p_full);
            icomp_q <= bus.mode ? 12'sd0 : sat12(i_full);
            state_q <= MOTOR;
          end
          MOTOR: begin
            lft_q   <= lft_nxt;
            rht_q   <= rht_nxt;
            upd_q   <= 1'b1;
            accum_q <= '0;
            p_q     <= '0;
            chnnl_q <= R_CHN[2:0];
            timer_q <= '0;
            state_q <= SETTLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.strt_cnv = strt_cnv_q;
  assign bus.chnnl    = chnnl_q;
  assign bus.IR_en    = ir_en;
  assign bus.LEDs     = error_q[11:4];
  assign bus.lft      = lft_q;
  assign bus.rht      = rht_q;
  assign bus.upd      = upd_q;
  assign bus.err_sat  = err_sat_q;

endmodule

// File: tb/tb_ir_pi_line_cntrl.sv
// Directed bench for ir_pi_line_cntrl: a default-timing instance for settle and
// PWM timing, and a short-timing instance with an A2D model for the control loop.
module tb_ir_pi_line_cntrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  ir_pi_line_cntrl_if #(.NUM_PAIRS(3)) m_if ();
  ir_pi_line_cntrl_if #(.NUM_PAIRS(3)) d_if ();

  ir_pi_line_cntrl #(.SETTLE_CYC(20), .SHORT_CYC(6), .FWD_MAX(60)) u_main (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  ir_pi_line_cntrl u_dflt (
    .clk (clk),
    .rst (rst),
    .bus (d_if)
  );

  // A2D model for the main instance: result returned 3 cycles after strt_cnv.
  logic [11:0] a2d_tbl [8];
  int m_cnt = 0;
  always @(negedge clk) begin
    m_if.cnv_cmplt = 1'b0;
    if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_if.cnv_cmplt = 1'b1;
        m_if.A2D_res   = a2d_tbl[m_if.chnnl];
      end
    end
    if (m_if.strt_cnv === 1'b1) m_cnt = 3;
  end

  task automatic set_tbl(input logic [11:0] v);
    for (int i = 0; i < 8; i++) a2d_tbl[i] = v;
  endtask

  task automatic restart(input logic mode);
    m_if.go = 1'b0;
    repeat (8) @(negedge clk);
    m_if.mode = mode;
    m_if.go   = 1'b1;
  endtask

  task automatic wait_upd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_if.upd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    m_if.go = 1'b0; m_if.mode = 1'b0;
    d_if.go = 1'b0; d_if.mode = 1'b0; d_if.cnv_cmplt = 1'b0; d_if.A2D_res = 12'h000;
    set_tbl(12'h100);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({m_if.strt_cnv, m_if.chnnl, m_if.IR_en, m_if.LEDs, m_if.lft, m_if.rht,
         m_if.upd, m_if.err_sat} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: outputs %h %h %h %h %h %h %h %h, required all 0",
               m_if.strt_cnv, m_if.chnnl, m_if.IR_en, m_if.LEDs, m_if.lft, m_if.rht,
               m_if.upd, m_if.err_sat);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({d_if.strt_cnv, d_if.chnnl, d_if.IR_en, d_if.LEDs, d_if.lft, d_if.rht,
         d_if.upd, d_if.err_sat} !== '0) begin
      n_fail++;
      $display("FAIL reset_dflt_idle: outputs not all 0 after reset release");
    end
  endtask

  task automatic test_settle_timing;
    int  n = 0, hi = 0;
    bit  other = 1'b0;
    d_if.go = 1'b1;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_assert++;
        if (d_if.chnnl !== 3'd1) begin
          n_fail++;
          $display("FAIL settle_chnnl: got %0d required 1", d_if.chnnl);
        end
      end
      if (i <= 240 && d_if.IR_en[0] === 1'b1) hi++;
      if (d_if.IR_en[2:1] !== 2'b00) other = 1'b1;
      if (d_if.strt_cnv === 1'b1) begin
        n = i;
        break;
      end
    end
    n_assert++;
    if (n - 1 != 4096) begin
      n_fail++;
      $display("FAIL settle_strt_cnv: pulse after %0d cycles required 4096", n - 1);
    end
    n_assert++;
    if (hi != 140) begin
      n_fail++;
      $display("FAIL pwm_duty: IR_en[0] high %0d of 240 required 140", hi);
    end
    n_assert++;
    if (other) begin
      n_fail++;
      $display("FAIL ir_en_other: IR_en[2:1] active=1 required 0 while pair0 active");
    end
    @(negedge clk);
    n_assert++;
    if (d_if.strt_cnv !== 1'b0) begin
      n_fail++;
      $display("FAIL strt_cnv_width: got %b on second cycle required 0", d_if.strt_cnv);
    end
    d_if.go = 1'b0;
    @(negedge clk);
    n_assert++;
    if (d_if.IR_en !== 3'b000) begin
      n_fail++;
      $display("FAIL dflt_stop_ir_en: got %b required 000", d_if.IR_en);
    end
  endtask

  task automatic test_basic;
    bit ok;
    set_tbl(12'h100);
    m_if.mode = 1'b0;
    m_if.go   = 1'b1;
    @(negedge clk);
    n_assert++;
    if (m_if.chnnl !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_chnnl: got %0d required 1", m_if.chnnl);
    end
    wait_upd(ok);
    n_assert++;
    if (!ok || m_if.lft !== 12'sd1 || m_if.rht !== 12'sd1 ||
        m_if.err_sat !== 1'b0 || m_if.LEDs !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_upd: ok=%0d lft=%0d rht=%0d sat=%b leds=%h required 1 1 1 0 00",
               ok, m_if.lft, m_if.rht, m_if.err_sat, m_if.LEDs);
    end
    @(negedge clk);
    n_assert++;
    if (m_if.upd !== 1'b0) begin
      n_fail++;
      $display("FAIL upd_width: got %b required 0", m_if.upd);
    end
  endtask

  task automatic test_pi;
    logic signed [11:0] exp_l [4] = '{12'sd193, 12'sd194, 12'sd195, 12'sd201};
    logic signed [11:0] exp_r [4] = '{-12'sd191, -12'sd190, -12'sd189, -12'sd193};
    bit ok;
    set_tbl(12'h100);
    a2d_tbl[1] = 12'h180;
    restart(1'b0);
    for (int k = 1; k <= 4; k++) begin
      wait_upd(ok);
      n_assert++;
      if (!ok || m_if.lft !== exp_l[k-1] || m_if.rht !== exp_r[k-1]) begin
        n_fail++;
        $display("FAIL pi_loop%0d: lft=%0d rht=%0d required %0d %0d",
                 k, m_if.lft, m_if.rht, exp_l[k-1], exp_r[k-1]);
      end
      if (k == 1) begin
        n_assert++;
        if (m_if.LEDs !== 8'h08 || m_if.err_sat !== 1'b0) begin
          n_fail++;
          $display("FAIL pi_leds: leds=%h sat=%b required 08 0", m_if.LEDs, m_if.err_sat);
        end
      end
    end
  endtask

  task automatic test_p_only;
    bit ok;
    logic signed [11:0] el, er;
    set_tbl(12'h100);
    a2d_tbl[1] = 12'h180;
    restart(1'b1);
    for (int k = 1; k <= 8; k++) begin
      wait_upd(ok);
      el = 12'(k + 192);
      er = 12'(k - 192);
      n_assert++;
      if (!ok || m_if.lft !== el || m_if.rht !== er) begin
        n_fail++;
        $display("FAIL ponly_loop%0d: lft=%0d rht=%0d required %0d %0d",
                 k, m_if.lft, m_if.rht, el, er);
      end
    end
  endtask

  task automatic test_saturation;
    bit ok;
    set_tbl(12'h100);
    a2d_tbl[3] = 12'hFFF;
    a2d_tbl[7] = 12'h000;
    restart(1'b0);
    wait_upd(ok);
    n_assert++;
    if (!ok || m_if.err_sat !== 1'b1 || m_if.LEDs !== 8'h7F) begin
      n_fail++;
      $display("FAIL sat_flag: sat=%b leds=%h required 1 7f", m_if.err_sat, m_if.LEDs);
    end
    n_assert++;
    if (m_if.lft !== 12'sd2047 || m_if.rht !== -12'sd2046) begin
      n_fail++;
      $display("FAIL sat_loop1: lft=%0d rht=%0d required 2047 -2046", m_if.lft, m_if.rht);
    end
    for (int k = 2; k <= 4; k++) wait_upd(ok);
    n_assert++;
    if (!ok || m_if.lft !== 12'sd2047 || m_if.rht !== -12'sd2048) begin
      n_fail++;
      $display("FAIL sat_loop4: lft=%0d rht=%0d required 2047 -2048", m_if.lft, m_if.rht);
    end
  endtask

  task automatic test_go_drop;
    bit ok;
    int cnt = 0;
    bit busy = 1'b0;
    set_tbl(12'h100);
    a2d_tbl[1] = 12'h180;
    restart(1'b0);
    wait_upd(ok);
    n_assert++;
    if (!ok || m_if.lft !== 12'sd193) begin
      n_fail++;
      $display("FAIL drop_pre: lft=%0d required 193", m_if.lft);
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (m_if.strt_cnv === 1'b1) cnt++;
      if (cnt == 2) break;
    end
    n_assert++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL drop_reach_conv_l: strt_cnv pulses %0d required 2", cnt);
    end
    m_if.go = 1'b0;
    @(negedge clk);
    n_assert++;
    if (m_if.lft !== 12'sd0 || m_if.rht !== 12'sd0 || m_if.IR_en !== 3'b000 ||
        m_if.LEDs !== 8'h08) begin
      n_fail++;
      $display("FAIL drop_idle: lft=%0d rht=%0d ir=%b leds=%h required 0 0 000 08",
               m_if.lft, m_if.rht, m_if.IR_en, m_if.LEDs);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_if.strt_cnv !== 1'b0 || m_if.upd !== 1'b0 || m_if.IR_en !== 3'b000) busy = 1'b1;
    end
    n_assert++;
    if (busy) begin
      n_fail++;
      $display("FAIL drop_stray_cmplt: activity=1 while stopped required 0");
    end
    m_if.go = 1'b1;
    @(negedge clk);
    n_assert++;
    if (m_if.chnnl !== 3'd1) begin
      n_fail++;
      $display("FAIL drop_restart_chnnl: got %0d required 1", m_if.chnnl);
    end
    wait_upd(ok);
    n_assert++;
    if (!ok || m_if.lft !== 12'sd193 || m_if.rht !== -12'sd191) begin
      n_fail++;
      $display("FAIL drop_restart_upd: lft=%0d rht=%0d required 193 -191", m_if.lft, m_if.rht);
    end
  endtask

  task automatic test_fwd_sat;
    bit ok;
    logic signed [11:0] e;
    set_tbl(12'h100);
    restart(1'b0);
    for (int k = 1; k <= 64; k++) begin
      wait_upd(ok);
      e = (k < 60) ? 12'(k) : 12'sd60;
      n_assert++;
      if (!ok || m_if.lft !== e || m_if.rht !== e) begin
        n_fail++;
        $display("FAIL fwd_loop%0d: lft=%0d rht=%0d required %0d", k, m_if.lft, m_if.rht, e);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_settle_timing();
    test_basic();
    test_pi();
    test_p_only();
    test_saturation();
    test_go_drop();
    test_fwd_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_pi_line_cntrl.md
Name: ir_pi_line_cntrl

Overview:
Parametrised successor to the line-follower motion controller. It scans NUM_PAIRS right/left IR sensor pairs through the shared A2D, forms a weighted, saturated error, and runs a PI loop with a ramped forward speed to drive signed left/right motor commands. It adds a configurable pair count, channel map, timing, gains and a P-only mode, plus an update strobe and an error-saturation flag.

Parameters:
NUM_PAIRS, 3, sensor pairs scanned; pair k weight = 2^k (k=0 innermost)
R_CHN, {3'd3,3'd4,3'd1}, packed A2D channel of right sensor per pair (pair0 in LSBs)
L_CHN, {3'd7,3'd2,3'd0}, packed A2D channel of left sensor per pair
SETTLE_CYC, 4096, IR settle cycles before the right-sensor conversion
SHORT_CYC, 32, settle cycles before the left-sensor conversion
PWM_PERIOD, 240, IR emitter PWM period in clocks
PWM_DUTY, 140, PWM high cycles per period
P_GAIN, 12, unsigned proportional gain; Pcomp = (Error*P_GAIN)>>>P_SHIFT
P_SHIFT, 3, proportional shift
I_GAIN, 5, unsigned integral gain; Icomp = (Intgrl*I_GAIN)>>>I_SHIFT
I_SHIFT, 3, integral shift
INT_DEC, 4, integrate once every INT_DEC loops
FWD_MAX, 1792, forward speed ceiling

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
go  in  1  run enable; low forces idle
mode  in  1  0 = PI, 1 = P-only
cnv_cmplt  in  1  A2D conversion done (1-cycle pulse)
A2D_res  in  12  unsigned A2D result, valid when cnv_cmplt=1
strt_cnv  out  1  A2D start pulse
chnnl  out  3  A2D channel select
IR_en  out  NUM_PAIRS  per-pair emitter enable
LEDs  out  8  Error[11:4]
lft  out  12  signed left motor command
rht  out  12  signed right motor command
upd  out  1  1-cycle pulse when lft/rht are updated
err_sat  out  1  last Error clamped

Behaviour:
- Reset: all outputs 0; internal Accum, Error, Intgrl, Fwd, int counter, pair index, timer and PWM counter are 0; state IDLE.
- States: IDLE, SETTLE, CONV_R, SHORT, CONV_L, ERR, INTG, PCMP, MOTOR.
- IDLE: on go=1 → SETTLE; pair index p=0, chnnl=R_CHN[p], timer=0, Accum=0.
- SETTLE: timer counts up. In the cycle timer==SETTLE_CYC-1, strt_cnv=1 for exactly 1 cycle → CONV_R.
- CONV_R: on cnv_cmplt, Accum += A2D_res<<p (signed 18-bit), chnnl=L_CHN[p], timer=0 → SHORT.
- SHORT: timer counts up. In the cycle timer==SHORT_CYC-1, strt_cnv=1 → CONV_L.
- CONV_L: on cnv_cmplt, Accum -= A2D_res<<p. If p<NUM_PAIRS-1: p++, chnnl=R_CHN[p], timer=0 → SETTLE. Otherwise → ERR.
- IR_en[p] = PWM high during SETTLE/CONV_R/SHORT/CONV_L; all other bits are 0. IR_en is 0 in all other states.
- PWM: counter 0..PWM_PERIOD-1 runs freely when not IDLE; high while counter < PWM_DUTY.
- ERR: Error = Accum clamped to [-2048,2047]; err_sat = clamp occurred; Fwd = min(Fwd+1, FWD_MAX) → INTG.
- INTG: int counter increments. When it wraps at INT_DEC-1 and mode=0: Intgrl = sat12(Intgrl + (Error>>>4)). mode=1 holds Intgrl → PCMP.
- PCMP: Pcomp = sat12((Error*P_GAIN)>>>P_SHIFT). Icomp = mode ? 0 : sat12((Intgrl*I_GAIN)>>>I_SHIFT). Both are registered → MOTOR.
- MOTOR: lft = sat12(Fwd+Pcomp+Icomp), rht = sat12(Fwd-Pcomp-Icomp), upd=1 for this cycle. Then Accum=0, p=0, chnnl=R_CHN[0], timer=0 → SETTLE.
- go=0 in any state: next cycle IDLE, strt_cnv=0, IR_en=0, lft=rht=Fwd=Intgrl=0, int counter=0. Error, LEDs and err_sat are held.
- cnv_cmplt outside CONV_R/CONV_L is ignored. A stray cnv_cmplt does not advance SETTLE or SHORT.
- sat12 means clamp to [-2048,2047]. Intermediate products use ≥24 bits signed.

Test Plan:
- Reset then go=1 → chnnl=1 and strt_cnv pulses exactly 4096 cycles after SETTLE entry. All A2D_res=0x100 → Error=0, first upd gives lft=rht=1, err_sat=0.
- Pair0 right=0x180, all others 0x100, mode=0 → Error=128, LEDs=0x08. Loop1: lft=193, rht=-191. After loop4: Intgrl=8, Icomp=5, lft=4+192+5=201.
- Same stimulus with mode=1 across 8 loops → Intgrl stays 0, Icomp=0, lft=Fwd+192.
- Pair2 right=0xFFF, left=0, all others equal → Error=2047, err_sat=1, LEDs=0x7F. lft saturates to 2047, rht saturates to -2048.
- go dropped during CONV_L → next cycle IDLE, lft=rht=0, IR_en=0. A later cnv_cmplt is ignored. Re-assert go → fresh scan from pair 0 with Fwd=1 on the first upd.
- Run 2000 loops → Fwd holds at 1792. IR_en[p] duty is 140/240 while pair p is active.
